simon_datapath_p: RTL

- Parametrised next-generation Simon datapath. Stores the player-built pattern sequence and replays it. Checks player entries against the stored sequence.
- Generalised over pattern width and sequence depth. Adds a 2-bit legality mode, saturating pointers, a sticky mismatch flag and a round counter.
- Driven by the Simon control FSM. Drives the pattern LEDs directly.

---
 rtl/simon_datapath_p.sv | 67 ++++++
 1 files changed

// File: rtl/simon_datapath_p.sv
// simon_datapath_p: Simon pattern store/replay/check datapath; optional SIMON_HISCORE_EN adds a high-score register.
module simon_datapath_p #(
  parameter int PAT_W = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SIMON_HISCORE_EN
  input  logic              hs_clr,
  output logic [ADDR_W:0]   hiscore,
`endif
  input  logic [1:0]        mode,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              last_inc,
  input  logic              i_inc,
  input  logic              i_clr,
  input  logic              mem_ld,
  input  logic              chk,
  input  logic              err_clr,
  input  logic              s_led_eq_pat,
  output logic              i_lt_last,
  output logic              i_eq_last,
  output logic              arr_full,
  output logic              correct_pat,
  output logic              legal,
  output logic              err,
  output logic [ADDR_W:0]   rounds,
  output logic [PAT_W-1:0]  pattern_leds
);
  localparam int DEPTH = 2**ADDR_W;
  logic [PAT_W-1:0] mem_q [DEPTH];
  logic [PAT_W-1:0] rd;
  logic [ADDR_W-1:0] i_q, i_d, last_q, last_d;
  logic err_q, err_d;
  logic [1:0] mode_q, mode_d;
  assign rd = mem_q[i_q];
  always_comb begin
    arr_full = &last_q;
    i_lt_last = i_q < last_q;
    i_eq_last = i_q == last_q;
    correct_pat = pattern == rd;
    legal = mode_q == 2'd0 ? $countones(pattern) == 1 :
            mode_q == 2'd1 ? |pattern :
            mode_q == 2'd2 ? 1'b1 : $countones(pattern) == 2;
    rounds = {1'b0, last_q};
    err = err_q;
    pattern_leds = s_led_eq_pat ? pattern : rd;
    i_d = rst || i_clr ? '0 : i_inc && i_lt_last ? i_q + 1'b1 : i_q;
    last_d = rst ? '0 : last_inc && !arr_full ? last_q + 1'b1 : last_q;
    err_d = rst || err_clr ? 1'b0 : chk && !correct_pat ? 1'b1 : err_q;
    mode_d = rst ? mode : mode_q;
  end
  always_ff @(posedge clk) begin
    i_q <= i_d;
    last_q <= last_d;
    err_q <= err_d;
    mode_q <= mode_d;
    if (mem_ld && !rst) mem_q[last_q] <= pattern;
  end
`ifdef SIMON_HISCORE_EN
  // Captures the finishing game's score on the reset that ends it.
  logic [ADDR_W:0] hiscore_q, hiscore_d;
  always_comb hiscore_d = hs_clr ? '0 : rst && rounds > hiscore_q ? rounds : hiscore_q;
  always_ff @(posedge clk) hiscore_q <= hiscore_d;
  assign hiscore = hiscore_q;
`endif
endmodule
